// File: rtl/display_scan_controller_pkg.sv
// Shared types for the stopwatch display scan path.
// The state enum and BCD width are also used by the stopwatch top level.
package scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } scan_state_t;

    localparam int BCD_W = 4;

endpackage

// File: rtl/display_scan_controller_if.sv
// Bus between the stopwatch core and the display scan controller.
// master = digit source / display consumer, slave = scan controller.
interface display_scan_if
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                          enable;
    logic [BCD_W*NUM_DIGITS-1:0]   digit_data;
    logic [NUM_DIGITS-1:0]         dp_mask;
    logic                          lz_suppress;
    logic [SEL_W-1:0]              digit_sel;
    logic [BCD_W-1:0]              bcd_out;
    logic                          dp_out;
    logic [NUM_DIGITS-1:0]         anode_n;
    logic                          frame_done;

    modport master (
        output enable, digit_data, dp_mask, lz_suppress,
        input  digit_sel, bcd_out, dp_out, anode_n, frame_done
    );

    modport slave (
        input  enable, digit_data, dp_mask, lz_suppress,
        output digit_sel, bcd_out, dp_out, anode_n, frame_done
    );

endinterface

// File: rtl/display_scan_controller_slot_timer.sv
// Slot timer for the scan controller: a counter cleared by the FSM on every
// state change, with terminal counts for the blanking gap and the drive phase.
module scan_slot_timer #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic blank_done_o,
    output logic slot_done_o
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart from zero whenever the FSM changes state.
    always_comb begin
        cnt_d = clear_i ? '0 : cnt_q + CNT_W'(1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last cycle of the blanking gap, and last cycle of the drive phase.
    assign blank_done_o = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign slot_done_o  = (cnt_q == CNT_W'(SCAN_DIV - BLANK_CYCLES - 1));

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scan sequencer. Each digit slot is a blanking
// gap followed by a drive phase; the digit word is snapshotted once per frame
// and leading zeros can be blanked. All outputs are registered from the
// next-state values so they line up exactly with the FSM state.
module display_scan_controller
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    display_scan_if.slave bus
);
    localparam int SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = BCD_W * NUM_DIGITS;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    scan_state_t             state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [DATA_W-1:0]       snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   dps_q, dps_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
    logic                    frame_done_q, frame_done_d;

    logic timer_clear;
    logic blank_done;
    logic slot_done;
    logic show;

    // A digit is blanked when it and every more significant snapshot digit
    // are zero; digit 0 is always shown so a zero reading is still visible.
    function automatic logic is_suppressed(input logic [DATA_W-1:0] snap,
                                           input logic [SEL_W-1:0]  idx,
                                           input logic              lz);
        logic zero_above;
        is_suppressed = 1'b0;
        zero_above    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (snap[BCD_W*i +: BCD_W] == '0);
            if (int'(idx) == i) begin
                is_suppressed = lz && zero_above;
            end
        end
    endfunction

    scan_slot_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (timer_clear),
        .blank_done_o (blank_done),
        .slot_done_o  (slot_done)
    );

    // Next state, digit advance, snapshot reload and registered output decode.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        snap_d       = snap_q;
        dps_d        = dps_q;
        frame_done_d = 1'b0;

        if (!bus.enable) begin
            state_d = S_IDLE;
            sel_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    sel_d   = '0;
                    snap_d  = bus.digit_data;
                    dps_d   = bus.dp_mask;
                end
                S_BLANK: begin
                    if (blank_done) begin
                        state_d = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (slot_done) begin
                        state_d = S_BLANK;
                        if (sel_q == LAST_SEL) begin
                            // Frame boundary: the only point where live digits are sampled.
                            sel_d        = '0;
                            frame_done_d = 1'b1;
                            snap_d       = bus.digit_data;
                            dps_d        = bus.dp_mask;
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                end
            endcase
        end

        // Counter restarts on every state change and is held at zero while idle.
        timer_clear = (state_d != state_q) || (state_d == S_IDLE);

        show      = (state_d == S_DRIVE) && !is_suppressed(snap_d, sel_d, bus.lz_suppress);
        bcd_d     = (state_d == S_IDLE) ? '0 : snap_d[BCD_W*int'(sel_d) +: BCD_W];
        dp_d      = show && dps_d[sel_d];
        anode_n_d = '1;
        if (show) begin
            anode_n_d[sel_d] = 1'b0;
        end
    end

    // State, snapshot and output registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            snap_q       <= '0;
            dps_q        <= '0;
            bcd_q        <= '0;
            dp_q         <= 1'b0;
            anode_n_q    <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            snap_q       <= snap_d;
            dps_q        <= dps_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            anode_n_q    <= anode_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.digit_sel  = sel_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.dp_out     = dp_q;
    assign bus.anode_n    = anode_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller (4 digits, 8-cycle slots, 2-cycle blank).
// A time-since-enable reference model predicts every output each cycle.
module tb_display_scan_controller;
    import scan_pkg::*;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    display_scan_if #(.NUM_DIGITS(N)) bus();

    display_scan_controller #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: whether scanning, cycles since scanning began, snapshot.
    bit             m_active = 1'b0;
    int             m_t      = 0;
    logic [4*N-1:0] m_snap   = '0;
    logic [N-1:0]   m_dps    = '0;
    logic [1:0]     e_sel;
    logic [N-1:0]   e_an;
    logic           e_dp, e_fd, e_drive;
    logic [3:0]     e_bcd;

    function automatic logic [7:0] obs();
        return {bus.digit_sel, bus.anode_n, bus.dp_out, bus.frame_done};
    endfunction

    function automatic logic [7:0] expv();
        return {e_sel, e_an, e_dp, e_fd};
    endfunction

    // Advance one clock, update the model from the inputs sampled at that edge,
    // then wait 1ns so outputs are read away from the edge.
    task automatic tick();
        int slot, pos;
        bit supp;
        @(posedge clk);
        e_fd = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_snap   = '0;
            m_dps    = '0;
        end else if (!bus.enable) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t      = 0;
            m_snap   = bus.digit_data;
            m_dps    = bus.dp_mask;
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                e_fd   = 1'b1;
                m_snap = bus.digit_data;
                m_dps  = bus.dp_mask;
            end
        end
        e_an    = '1;
        e_dp    = 1'b0;
        e_sel   = '0;
        e_bcd   = '0;
        e_drive = 1'b0;
        if (m_active) begin
            slot    = (m_t / DIV) % N;
            pos     = m_t % DIV;
            e_drive = (pos >= BLK);
            supp    = bus.lz_suppress && (slot != 0) && ((m_snap >> (4*slot)) == '0);
            e_sel   = 2'(slot);
            e_bcd   = m_snap[4*slot +: 4];
            if (e_drive && !supp) begin
                e_an[slot] = 1'b0;
                e_dp       = m_dps[slot];
            end
        end
        #1;
    endtask

    task automatic restart(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        bus.enable = 1'b0;
        tick();
        bus.digit_data  = d;
        bus.dp_mask     = dp;
        bus.lz_suppress = lz;
        bus.enable      = 1'b1;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.enable      = 1'b1;
        bus.digit_data  = 16'h5A5A;
        bus.dp_mask     = 4'hF;
        bus.lz_suppress = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if ({bus.digit_sel, bus.bcd_out, bus.dp_out, bus.anode_n, bus.frame_done} !== 12'b00_0000_0_1111_0) begin
                n_fail++;
                $display("FAIL reset_values c=%0d got sel=%0d bcd=%h dp=%b an=%b fd=%b want 0 0 0 1111 0",
                         c, bus.digit_sel, bus.bcd_out, bus.dp_out, bus.anode_n, bus.frame_done);
            end
        end
    endtask

    task automatic test_basic();
        int fd_at = -1;
        bus.digit_data = 16'h1234;
        bus.dp_mask    = 4'h0;
        reset          = 1'b0;
        for (int c = 0; c < 42; c++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL basic_model c=%0d got %h want %h", c, obs(), expv());
            end
            if (e_drive) begin
                n_chk++;
                if (bus.bcd_out !== e_bcd) begin
                    n_fail++;
                    $display("FAIL basic_bcd c=%0d got %h want %h", c, bus.bcd_out, e_bcd);
                end
            end
            if (c == 1 || c == 2 || c == 10 || c == 26) begin
                n_chk++;
                if ({bus.anode_n, bus.bcd_out} !== ((c == 1)  ? {4'b1111, 4'h4} :
                                                    (c == 2)  ? {4'b1110, 4'h4} :
                                                    (c == 10) ? {4'b1101, 4'h3} : {4'b0111, 4'h1})) begin
                    n_fail++;
                    $display("FAIL basic_slot c=%0d got an=%b bcd=%h", c, bus.anode_n, bus.bcd_out);
                end
            end
            if (bus.frame_done && fd_at < 0) fd_at = c;
        end
        n_chk++;
        if (fd_at !== 32) begin
            n_fail++;
            $display("FAIL basic_frame_done got cycle %0d want 32", fd_at);
        end
    endtask

    task automatic test_lz();
        logic [3:0] low_seen = '0;
        int shown = 0;
        restart(16'h0005, 4'h0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL lz_model c=%0d got %h want %h", c, obs(), expv());
            end
            low_seen |= ~bus.anode_n;
        end
        n_chk++;
        if (low_seen !== 4'b0001) begin
            n_fail++;
            $display("FAIL lz_anodes got %b want 0001", low_seen);
        end
        restart(16'h0000, 4'h0, 1'b1);
        low_seen = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL lz0_model c=%0d got %h want %h", c, obs(), expv());
            end
            if (bus.anode_n == 4'b1110 && bus.bcd_out == 4'h0) shown++;
            low_seen |= ~bus.anode_n;
        end
        n_chk++;
        if (shown !== 12 || low_seen !== 4'b0001) begin
            n_fail++;
            $display("FAIL lz_zero_shown got %0d cycles anodes %b want 12 cycles 0001", shown, low_seen);
        end
    endtask

    task automatic test_live_change();
        restart(16'h1234, 4'h0, 1'b0);
        for (int c = 0; c < 48; c++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL live_model c=%0d got %h want %h", c, obs(), expv());
            end
            if (c == 18 || c == 26 || c == 34 || c == 42) begin
                n_chk++;
                if (bus.bcd_out !== ((c == 18) ? 4'h2 : (c == 26) ? 4'h1 : (c == 34) ? 4'h6 : 4'h7)) begin
                    n_fail++;
                    $display("FAIL live_snapshot c=%0d got %h", c, bus.bcd_out);
                end
            end
            if (c == 11) bus.digit_data = 16'h9876;
        end
    endtask

    task automatic test_enable_drop();
        restart(16'h1234, 4'h0, 1'b0);
        for (int c = 0; c <= 20; c++) tick();
        bus.enable = 1'b0;
        tick();
        n_chk++;
        if ({bus.anode_n, bus.digit_sel, bus.frame_done} !== {4'b1111, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_idle got an=%b sel=%0d fd=%b want 1111 0 0", bus.anode_n, bus.digit_sel, bus.frame_done);
        end
        bus.enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if ({bus.anode_n, bus.digit_sel} !== {((c < 2) ? 4'b1111 : 4'b1110), 2'd0}) begin
                n_fail++;
                $display("FAIL drop_restart c=%0d got an=%b sel=%0d", c, bus.anode_n, bus.digit_sel);
            end
        end
        // Dropping enable in the final drive cycle of a frame must not produce frame_done.
        restart(16'h4321, 4'h0, 1'b0);
        for (int c = 0; c <= 31; c++) tick();
        bus.enable = 1'b0;
        tick();
        n_chk++;
        if (obs() !== expv() || bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_last_slot got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_reset_fd();
        restart(16'h1234, 4'hF, 1'b0);
        for (int c = 0; c <= 32; c++) tick();
        n_chk++;
        if (bus.frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_fd_pulse got %b want 1", bus.frame_done);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if ({bus.digit_sel, bus.bcd_out, bus.dp_out, bus.anode_n, bus.frame_done} !== 12'b00_0000_0_1111_0) begin
            n_fail++;
            $display("FAIL rst_fd_values got sel=%0d bcd=%h dp=%b an=%b fd=%b want 0 0 0 1111 0",
                     bus.digit_sel, bus.bcd_out, bus.dp_out, bus.anode_n, bus.frame_done);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL rst_fd_resume c=%0d got %h want %h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_dp();
        logic dp_seen = 1'b0;
        int dp_cnt = 0, dp_bad = 0;
        restart(16'h0012, 4'b0100, 1'b1);
        for (int c = 0; c < 40; c++) begin
            tick();
            dp_seen |= bus.dp_out;
        end
        n_chk++;
        if (dp_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL dp_suppressed got dp seen=%b want 0", dp_seen);
        end
        restart(16'h0012, 4'b0100, 1'b0);
        for (int c = 0; c < 32; c++) begin
            tick();
            if (bus.dp_out) begin
                dp_cnt++;
                if (bus.digit_sel != 2'd2 || bus.anode_n != 4'b1011) dp_bad++;
            end
        end
        n_chk++;
        if (dp_cnt !== 6 || dp_bad !== 0) begin
            n_fail++;
            $display("FAIL dp_shown got %0d cycles (%0d misplaced) want 6 (0)", dp_cnt, dp_bad);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int c = 0; c < 3000; c++) begin
            tick();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL rand_model c=%0d got %h want %h", c, obs(), expv());
            end
            if (e_drive) begin
                n_chk++;
                if (bus.bcd_out !== e_bcd) begin
                    n_fail++;
                    $display("FAIL rand_bcd c=%0d got %h want %h", c, bus.bcd_out, e_bcd);
                end
            end
            reset      = ($urandom_range(0, 299) == 0);
            bus.enable = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 6) == 0) begin
                d = 16'($urandom);
                bus.digit_data = d >> (4 * $urandom_range(0, 4));
                bus.dp_mask    = 4'($urandom);
            end
            if ($urandom_range(0, 39) == 0) bus.lz_suppress = ~bus.lz_suppress;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_live_change();
        test_enable_drop();
        test_reset_fd();
        test_dp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
